flush_redirect_ctrl: RTL and testbench
======================================

# flush_redirect_ctrl

Sequences pipeline recovery after a write-back exception or ERET. It turns the WB exception/ERET event into a one-cycle pipeline flush. It then drains instruction-fetch responses that were already in flight when the flush happened, and finally presents the redirect target to pre-IF until the first fetch of that target is accepted. It sits between the WB stage, which drives the exception/ERET/EPC bus, and the IF stage's SRAM-like instruction interface.

## Interface
- EXC_ENTRY, 32'hbfc00380: exception vector returned as the redirect target.
- MAX_OUTST, 3: maximum number of accepted, unanswered instruction requests (range 1..3; counters are 2 bits).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- exc_eret_bus  in  34  {exc, eret, epc[31:0]}; exc and eret are already qualified with ws_valid.
- inst_req_fire  in  1  an instruction request was accepted this cycle (req & addr_ok).
- inst_data_ok  in  1  an instruction response was returned this cycle.
- flush  out  1  clears all pipeline stage valids at the next edge.
- req_block  out  1  pre-IF must not issue an instruction request this cycle.
- discard  out  1  IF must drop the response returned this cycle.
- redirect_valid  out  1  redirect_pc is the next fetch address.
- redirect_pc  out  32  redirect target.
- busy  out  1  the controller is not in IDLE.

## Operation
- Outstanding counter cnt:
  - Next value cnt_n = cnt + inst_req_fire - inst_data_ok.
  - If inst_data_ok arrives while cnt==0 and there is no fire, cnt stays at 0 (no underflow).
- Event: ev = exc | eret, sampled only in IDLE.
  - Target = EXC_ENTRY when exc=1 (exc has priority if both are set), otherwise epc.
- States: IDLE, DRAIN, REDIRECT.
  - IDLE:
    - flush = ev, combinational.
    - On ev, latch the target and set dcnt <= cnt_n.
    - Next state is DRAIN if cnt_n != 0, otherwise REDIRECT.
  - DRAIN:
    - discard = 1 and req_block = 1.
    - Each inst_data_ok decrements dcnt.
    - When inst_data_ok arrives with dcnt==1, go to REDIRECT at the next edge.
  - REDIRECT:
    - redirect_valid = 1 and redirect_pc = target; req_block = 0 unless cnt==MAX_OUTST.
    - inst_req_fire is the acknowledgment: go to IDLE at the next edge.
- exc and eret are ignored in DRAIN and REDIRECT, because the pipeline holds no valid instructions in those states.
- req_block = (state==DRAIN) | (cnt==MAX_OUTST) | (state==IDLE & ev).
- discard is 0 in IDLE: a response arriving in the event cycle is still dropped, because the IF stage is flushed in that same cycle.
- busy = state != IDLE.

## Timing
- Values after reset:
  - state = IDLE; cnt, dcnt and target = 0.
  - flush, req_block, discard, redirect_valid and busy = 0.
  - redirect_pc = 0.
- Event in cycle T:
  - flush = 1 in cycle T only.
  - busy = 1 from T+1.
- With no outstanding requests at T, redirect_valid = 1 from T+1 (minimum latency of 1 cycle).
- With N outstanding requests at T, redirect_valid rises the cycle after the N-th inst_data_ok.
- redirect_valid and redirect_pc hold steady until the inst_req_fire cycle, inclusive. The controller is back in IDLE the following cycle, so a new event can be accepted from then on.
- Simultaneous fire and data_ok in one cycle leaves cnt unchanged. This also holds in the event cycle, since dcnt takes cnt_n.
- reset asserted mid-DRAIN or mid-REDIRECT returns to the reset state at the next edge. Responses still in flight are then not discarded; the IF stage's own reset handles them.
- cnt never exceeds MAX_OUTST, because req_block prevents any further fire at the limit.

## Test plan
- Idle exception:
  - Stimulus: cnt=0, exc=1 with epc=32'h1234 for one cycle.
  - Response: flush pulses for 1 cycle. Next cycle, redirect_valid=1 with redirect_pc=32'hbfc00380. When inst_req_fire arrives 3 cycles later, the controller is back in IDLE the cycle after.
- ERET with drain:
  - Stimulus: two requests outstanding, eret=1 with epc=32'h8000_0100. Then data_ok arrives 2 and 5 cycles later.
  - Response: discard=1 on both of those cycles and req_block=1 throughout DRAIN. redirect_valid rises the cycle after the second data_ok, with redirect_pc=32'h8000_0100.
- Simultaneous events in the event cycle:
  - Stimulus: exc=1 and eret=1 together, plus fire=1 and data_ok=1 in the same cycle, with cnt=1.
  - Response: target=EXC_ENTRY, dcnt=1, and the state goes to DRAIN.
- Outstanding limit:
  - Stimulus: three fires with no responses.
  - Response: cnt=3 and req_block=1. After one data_ok, req_block=0 on the next cycle.
- Ignored events:
  - Stimulus: exc pulses again during DRAIN and during REDIRECT.
  - Response: no flush pulse, and target is unchanged.
- Reset mid-operation:
  - Stimulus: assert reset while in REDIRECT.
  - Response: at the next edge, state=IDLE and all outputs are 0.

Source files
------------

// File: rtl/flush_redirect_ctrl.sv
// Pipeline recovery sequencer: turns a WB exception/ERET into a flush, drains
// in-flight fetch responses, then presents the redirect target to pre-IF.
module flush_redirect_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'hbfc00380,
  parameter logic [1:0]  MAX_OUTST = 2'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [33:0] exc_eret_bus,
  input  logic        inst_req_fire,
  input  logic        inst_data_ok,
  output logic        flush,
  output logic        req_block,
  output logic        discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  cnt;
  logic [1:0]  cnt_n;
  logic [1:0]  dcnt;
  logic [1:0]  dcnt_n;
  logic [31:0] target;
  logic [31:0] target_n;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic        ev;

  assign exc  = exc_eret_bus[33];
  assign eret = exc_eret_bus[32];
  assign epc  = exc_eret_bus[31:0];
  assign ev   = exc | eret;

  // Outstanding-request counter next value; a stray response at zero is ignored.
  always_comb begin
    cnt_n = cnt;
    if (inst_req_fire && !inst_data_ok) begin
      cnt_n = cnt + 2'd1;
    end else if (!inst_req_fire && inst_data_ok && (cnt != 2'd0)) begin
      cnt_n = cnt - 2'd1;
    end else begin
      cnt_n = cnt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_n        = state;
    dcnt_n         = dcnt;
    target_n       = target;
    flush          = 1'b0;
    discard        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    req_block      = (cnt == MAX_OUTST);
    case (state)
      IDLE: begin
        if (ev) begin
          flush     = 1'b1;
          req_block = 1'b1;
          target_n  = exc ? EXC_ENTRY : epc;
          dcnt_n    = cnt_n;
          state_n   = (cnt_n != 2'd0) ? DRAIN : REDIRECT;
        end else begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        discard   = 1'b1;
        req_block = 1'b1;
        if (inst_data_ok) begin
          dcnt_n  = (dcnt != 2'd0) ? (dcnt - 2'd1) : 2'd0;
          state_n = (dcnt == 2'd1) ? REDIRECT : DRAIN;
        end else begin
          state_n = DRAIN;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
        // The first accepted fetch of the target is the acknowledgment.
        if (inst_req_fire) begin
          state_n = IDLE;
        end else begin
          state_n = REDIRECT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // State, counters and latched target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      dcnt   <= 2'd0;
      target <= 32'h0000_0000;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dcnt   <= dcnt_n;
      target <= target_n;
    end
  end

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Self-checking bench: per-cycle comparison against a counting model plus
// hand-computed literal checks along the directed scenarios.
module tb_flush_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic        fire;
  logic        ok;
  logic        flush;
  logic        req_block;
  logic        discard;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  always #5 clk = ~clk;

  flush_redirect_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .exc_eret_bus   ({exc, eret, epc}),
    .inst_req_fire  (fire),
    .inst_data_ok   (ok),
    .flush          (flush),
    .req_block      (req_block),
    .discard        (discard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // Model: outstanding requests, responses still to discard, redirect pending.
  int          m_outst = 0;
  int          m_drain = 0;
  bit          m_redir = 1'b0;
  logic [31:0] m_tgt   = 32'h0;
  bit          chk_en  = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int n;
    bit idle;
    n = m_outst + int'(fire) - int'(ok);
    if (n < 0) n = 0;
    idle = (m_drain == 0) && !m_redir;
    if (reset) begin
      m_outst = 0; m_drain = 0; m_redir = 1'b0; m_tgt = 32'h0;
    end else begin
      if (idle && (exc || eret)) begin
        m_tgt = exc ? 32'hbfc00380 : epc;
        if (n > 0) m_drain = n;
        else m_redir = 1'b1;
      end else if (m_drain > 0) begin
        if (ok) begin
          m_drain--;
          if (m_drain == 0) m_redir = 1'b1;
        end
      end else if (m_redir && fire) begin
        m_redir = 1'b0;
      end
      m_outst = n;
    end
  endtask

  // One clock: advance the model on the edge, drive new inputs, stop at the negedge.
  task automatic cyc(input bit r, input bit e, input bit er, input logic [31:0] pc,
                     input bit f, input bit k);
    @(posedge clk);
    model_step();
    #1;
    reset = r; exc = e; eret = er; epc = pc; fire = f; ok = k;
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Compare the DUT against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      bit idle;
      bit e_flush;
      idle    = (m_drain == 0) && !m_redir;
      e_flush = idle && (exc || eret);
      check("flush", {31'b0, flush}, {31'b0, e_flush});
      check("discard", {31'b0, discard}, {31'b0, m_drain > 0});
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_redir});
      check("busy", {31'b0, busy}, {31'b0, !idle});
      check("req_block", {31'b0, req_block},
            {31'b0, (m_drain > 0) || (m_outst == 3) || e_flush});
      if (m_redir) check("redirect_pc", redirect_pc, m_tgt);
    end
  end

  initial begin
    reset = 1'b1; exc = 1'b0; eret = 1'b0; epc = 32'h0; fire = 1'b0; ok = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle_cyc();
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_req_block", {31'b0, req_block}, 32'd0);
    check("rst_valid", {31'b0, redirect_valid}, 32'd0);
    check("rst_pc", redirect_pc, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);

    // Stray response at cnt 0, then idle exception with nothing outstanding.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0);
    check("exc_flush", {31'b0, flush}, 32'd1);
    check("exc_busy_t", {31'b0, busy}, 32'd0);
    idle_cyc();
    check("exc_valid", {31'b0, redirect_valid}, 32'd1);
    check("exc_pc", redirect_pc, 32'hbfc00380);
    check("exc_flush_t1", {31'b0, flush}, 32'd0);
    idle_cyc();
    idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("exc_valid_ack", {31'b0, redirect_valid}, 32'd1);
    idle_cyc();
    check("exc_idle_busy", {31'b0, busy}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // ERET with two outstanding; exc pulses during DRAIN and REDIRECT are ignored.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
    check("eret_flush", {31'b0, flush}, 32'd1);
    idle_cyc();
    check("drain_block", {31'b0, req_block}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("drain_discard1", {31'b0, discard}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'hdead_beef, 1'b0, 1'b0);
    check("drain_no_flush", {31'b0, flush}, 32'd0);
    idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("drain_discard2", {31'b0, discard}, 32'd1);
    check("drain_valid_low", {31'b0, redirect_valid}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0bad_0bad, 1'b0, 1'b0);
    check("eret_valid", {31'b0, redirect_valid}, 32'd1);
    check("eret_pc", redirect_pc, 32'h8000_0100);
    check("redir_no_flush", {31'b0, flush}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Simultaneous exc+eret with fire+data_ok at cnt 1.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h5555_5555, 1'b1, 1'b1);
    check("sim_flush", {31'b0, flush}, 32'd1);
    idle_cyc();
    check("sim_drain", {31'b0, discard}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle_cyc();
    check("sim_pc", redirect_pc, 32'hbfc00380);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Outstanding limit.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle_cyc();
    check("limit_block", {31'b0, req_block}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle_cyc();
    check("limit_release", {31'b0, req_block}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Reset while in REDIRECT.
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_4000, 1'b0, 1'b0);
    idle_cyc();
    check("pre_rst_valid", {31'b0, redirect_valid}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle_cyc();
    check("mid_rst_valid", {31'b0, redirect_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_pc", redirect_pc, 32'h0);
    check("mid_rst_block", {31'b0, req_block}, 32'd0);
    idle_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
